// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP control sequencer: opcodes, control-word
// bit positions and T-state indices.
package sap_ctrl_pkg;

    localparam int OPCODE_W_DEF = 4;
    localparam int T_STATES_DEF = 6;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bit positions in the 12-bit control word; *_N bits are active-low.
    localparam int CON_CP   = 11;
    localparam int CON_EP_N = 10;
    localparam int CON_LM_N = 9;
    localparam int CON_CE_N = 8;
    localparam int CON_LI_N = 7;
    localparam int CON_EI_N = 6;
    localparam int CON_LA_N = 5;
    localparam int CON_EA_N = 4;
    localparam int CON_SU   = 3;
    localparam int CON_EU_N = 2;
    localparam int CON_LB_N = 1;
    localparam int CON_LO_N = 0;

    localparam logic [11:0] CON_IDLE = 12'h7F7;

    localparam int T1_IDX = 0;
    localparam int T2_IDX = 1;
    localparam int T3_IDX = 2;
    localparam int T4_IDX = 3;
    localparam int T5_IDX = 4;
    localparam int T6_IDX = 5;

endpackage

// File: rtl/t_ring_counter.sv
// One-hot T-state ring. Advances only on enabled cycles and parks at all
// zeros when told to halt.
module t_ring_counter #(
    parameter int T_STATES = 6
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic                halt,
    output logic [T_STATES-1:0] tstate
);

    always_ff @(posedge clk) begin
        if (!clr) begin
            tstate <= T_STATES'(1);
        end else if (en) begin
            if (halt) begin
                tstate <= '0;
            end else if ($onehot(tstate)) begin
                tstate <= {tstate[T_STATES-2:0], tstate[T_STATES-1]};
            end else begin
                // Corrupted encodings fall back to T1 rather than propagating.
                tstate <= T_STATES'(1);
            end
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// SAP control sequencer: T-state ring, control-word decode and
// run/step/halt gating for the datapath.
module control_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int OPCODE_W = OPCODE_W_DEF,
    parameter int T_STATES = T_STATES_DEF
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                run,
    input  logic                step,
    output logic [11:0]         con,
    output logic [T_STATES-1:0] tstate,
    output logic                hlt
);

    logic        en;
    logic        halt_now;
    logic [11:0] con_dec;

    assign en       = clr & ~hlt & (run | step);
    assign halt_now = en & tstate[T4_IDX] & (opcode == OP_HLT);

    t_ring_counter #(.T_STATES(T_STATES)) u_ring (
        .clk    (clk),
        .clr    (clr),
        .en     (en),
        .halt   (halt_now),
        .tstate (tstate)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            hlt <= 1'b0;
        end else if (halt_now) begin
            hlt <= 1'b1;
        end
    end

    // Start from idle and flip only the bits a micro-op asserts.
    always_comb begin
        con_dec = CON_IDLE;
        if (tstate[T1_IDX]) begin
            con_dec[CON_EP_N] = 1'b0;
            con_dec[CON_LM_N] = 1'b0;
        end else if (tstate[T2_IDX]) begin
            con_dec[CON_CP] = 1'b1;
        end else if (tstate[T3_IDX]) begin
            con_dec[CON_CE_N] = 1'b0;
            con_dec[CON_LI_N] = 1'b0;
        end else if (tstate[T4_IDX]) begin
            case (opcode)
                OP_LDA, OP_ADD, OP_SUB: begin
                    con_dec[CON_EI_N] = 1'b0;
                    con_dec[CON_LM_N] = 1'b0;
                end
                OP_OUT: begin
                    con_dec[CON_EA_N] = 1'b0;
                    con_dec[CON_LO_N] = 1'b0;
                end
                default: ;
            endcase
        end else if (tstate[T5_IDX]) begin
            case (opcode)
                OP_LDA: begin
                    con_dec[CON_CE_N] = 1'b0;
                    con_dec[CON_LA_N] = 1'b0;
                end
                OP_ADD, OP_SUB: begin
                    con_dec[CON_CE_N] = 1'b0;
                    con_dec[CON_LB_N] = 1'b0;
                end
                default: ;
            endcase
        end else if (tstate[T6_IDX]) begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
                con_dec[CON_EU_N] = 1'b0;
                con_dec[CON_LA_N] = 1'b0;
                con_dec[CON_SU]   = (opcode == OP_SUB);
            end
        end
    end

    // Stalled or reset cycles present idle so each micro-op fires exactly once.
    assign con = en ? con_dec : CON_IDLE;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Control sequencer for the 8-bit SAP-style computer. It steps a six-state one-hot T-state ring (fetch T1-T3, execute T4-T6). From the current T-state and the instruction-register opcode it decodes the 12-bit control word that drives the register loads and output enables, the PC increment and the ALU function. It also provides free-run, single-step and halt control for the whole datapath.

Parameters:
OPCODE_W, 4, opcode width taken from the upper nibble of the instruction register
T_STATES, 6, ring length. Fixed at 6 for this ISA; any larger value only adds idle states.

Ports:
clk  in  1  system clock; all state updates on the rising edge
clr  in  1  synchronous, active-low reset, sampled on the rising edge of clk
opcode  in  OPCODE_W  instruction-register opcode; must be stable from T4 through T6
run  in  1  1 = free-run, one T-state per cycle
step  in  1  one-cycle pulse advances exactly one T-state while run=0
con  out  12  control word: combinational decode of the registered T-state and opcode
tstate  out  T_STATES  one-hot current T-state; all zeros while halted
hlt  out  1  halted flag, registered

Behaviour:
- Control word bit map: [11] cp (PC increment, active-high); [10] ep_n (PC out); [9] lm_n (MAR load); [8] ce_n (RAM out); [7] li_n (IR load); [6] ei_n (IR operand out); [5] la_n (A load); [4] ea_n (A out); [3] su (1 = subtract); [2] eu_n (ALU out); [1] lb_n (B load); [0] lo_n (output register load).
- Bits ending in _n are active-low, matching the datapath registers' active-low load and enable inputs.
- CON_IDLE = 12'h7F7: nothing is asserted.
- Reset (clr=0 at a rising edge): tstate<=6'b000001 (T1) and hlt<=0 at that edge. con = CON_IDLE in any cycle where clr=0. Reset has priority over run, step and halt, and aborts any instruction in progress.
- Enabled cycle: en = clr & ~hlt & (run | step).
  - When en=1: con = decode(tstate, opcode), and the ring advances at the end of the cycle (T6 wraps to T1).
  - When en=0: con = CON_IDLE and the state holds. A T-state's micro-ops therefore happen exactly once, regardless of stalls.
- If run=1, step is ignored (no double advance).
- Fetch (independent of opcode):
  - T1 = ep_n, lm_n asserted (0x1F7)
  - T2 = cp (0xFF7)
  - T3 = ce_n, li_n (0x677)
- Execute:
  - LDA 0x0: T4 ei_n, lm_n (0x5B7); T5 ce_n, la_n (0x6D7); T6 idle (0x7F7).
  - ADD 0x1: T4 0x5B7; T5 ce_n, lb_n (0x6F5); T6 eu_n, la_n, su=0 (0x7D3).
  - SUB 0x2: same as ADD except T6 su=1 (0x7DB).
  - OUT 0xE: T4 ea_n, lo_n (0x7E6); T5 and T6 idle.
  - HLT 0xF: T4 con idle. At the end of an enabled T4, hlt<=1 and tstate<=0. Halted state persists until clr; run and step are ignored while halted.
  - All other opcodes are NOPs: T4-T6 idle, then wrap to T1.
- Opcode changes during T1-T3 have no effect, because con does not depend on opcode in those states.
- Latency: an instruction takes 6 enabled cycles; HLT takes 4 enabled cycles to assert hlt.
- No X on outputs after the first reset edge. tstate is always one-hot or all zeros; an illegal encoding recovers to T1 on the next enabled edge.

Decomposition:
- Package sap_ctrl_pkg:
  - opcode localparams: OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT
  - CON_* bit-index constants
  - CON_IDLE
  - T-state index constants
- Sub-module t_ring_counter: one-hot ring with clk, clr, en, halt inputs. The control_sequencer top holds the decode logic and the hlt flag.

Test Plan:
1. Reset: clr=0 for 2 cycles with run=1, then clr=1 -> while clr=0, con=12'h7F7; after the edge, tstate=6'b000001, hlt=0.
2. Free-run LDA (opcode=0x0, run=1) -> con sequence 1F7, FF7, 677, 5B7, 6D7, 7F7, then 1F7 on wrap, with tstate walking 000001..100000.
3. ADD, then SUB, then OUT back to back -> T6 gives 7D3 for ADD and 7DB for SUB; OUT T4 gives 7E6; T5 for ADD/SUB gives 6F5.
4. Single-step: run=0, step pulsed 1 cycle every 4 cycles -> con=7F7 on non-pulse cycles, decoded word only on pulse cycles, tstate advances exactly once per pulse.
5. HLT: opcode=0xF, run=1 -> after 4 cycles hlt=1, tstate=0, con=7F7, held for 20+ cycles despite run/step toggling. clr=0 then clears hlt and resumes at T1.
6. Reset mid-instruction: clr=0 during T5 of ADD -> no lb_n in that cycle (con=7F7), tstate=T1 next; also opcode=0x7 -> T4-T6 all 7F7.
